// File: rtl/decim_channel_scheduler.sv
// Round-robin scheduler sharing one FIR decimation MAC between NumChannels input channels.
// Define DECIM_SCHED_OVERRUN_EN to compile in the sticky Overrun_o flags and OvrClr_i.
module decim_channel_scheduler #(
  parameter int NumChannels  = 4,
  parameter int FilterLength = 16,
  parameter int DecimationK  = 2
) (
  input  logic                     Clk_i,
  input  logic                     Rst_i,
  input  logic [NumChannels-1:0]   DataNd_i,
  input  logic                     OvrClr_i,
  output logic [NumChannels-1:0]   WrEn_o,
  output logic [4*NumChannels-1:0] WrAddr_o,
  output logic [1:0]               RdChan_o,
  output logic [3:0]               DataAddr_o,
  output logic [3:0]               CoeffAddr_o,
  output logic                     StartAcc_o,
  output logic                     DataValid_o,
  output logic [1:0]               OutChan_o,
  output logic                     Busy_o,
  output logic [NumChannels-1:0]   Overrun_o
);

  // state  | meaning
  // StIdle | no run in progress, waiting for a pending request
  // StRun  | presenting one tap per cycle for the granted channel
  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1} state_t;

  state_t                 state, stateNxt;
  logic [3:0]             wrPtr [NumChannels];
  logic [3:0]             phase [NumChannels];
  logic [3:0]             base  [NumChannels];
  logic [NumChannels-1:0] pending, trigger;
  logic [1:0]             lastGrant, winner;
  logic                   anyPending, found, grant, advance, lastTap;
  logic [3:0]             tap;
  logic [2:0]             startPipe, validPipe;
  logic [1:0]             chanPipe [3];

  assign WrEn_o     = DataNd_i;
  assign anyPending = |pending;
  assign lastTap    = (tap == 4'(FilterLength - 1));

  always_comb begin
    WrAddr_o = '0;
    trigger  = '0;
    for (int c = 0; c < NumChannels; c++) begin
      WrAddr_o[4*c +: 4] = wrPtr[c];
      trigger[c]         = DataNd_i[c] && (phase[c] == 4'd0);
    end
  end

  // Search starts one past the last granted channel.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NumChannels; i++) begin
      if (!found && pending[(int'(lastGrant) + i) % NumChannels]) begin
        winner = 2'((int'(lastGrant) + i) % NumChannels);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) state <= StIdle;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = StIdle;
    case (state)
      StIdle:  stateNxt = anyPending ? StRun : StIdle;
      StRun:   stateNxt = (!lastTap || anyPending) ? StRun : StIdle;
      default: stateNxt = StIdle;
    endcase
  end

  always_comb begin
    Busy_o  = 1'b0;
    grant   = 1'b0;
    advance = 1'b0;
    case (state)
      StIdle: grant = anyPending;
      StRun: begin
        Busy_o  = 1'b1;
        grant   = lastTap && anyPending;
        advance = !lastTap;
      end
      default: ;
    endcase
  end

  // A trigger always re-arms the request; a simultaneous grant only consumes the older one.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      pending <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        wrPtr[c] <= '0;
        phase[c] <= '0;
        base[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (DataNd_i[c]) begin
          wrPtr[c] <= wrPtr[c] + 4'd1;
          phase[c] <= (phase[c] == 4'(DecimationK - 1)) ? 4'd0 : phase[c] + 4'd1;
        end
        if (trigger[c]) begin
          pending[c] <= 1'b1;
          base[c]    <= wrPtr[c];
        end else if (grant && (winner == 2'(c))) begin
          pending[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      tap         <= '0;
      DataAddr_o  <= '0;
      CoeffAddr_o <= '0;
      RdChan_o    <= '0;
      lastGrant   <= 2'(NumChannels - 1);
    end else if (grant) begin
      tap         <= '0;
      DataAddr_o  <= base[winner];
      CoeffAddr_o <= '0;
      RdChan_o    <= winner;
      lastGrant   <= winner;
    end else if (advance) begin
      tap         <= tap + 4'd1;
      DataAddr_o  <= DataAddr_o - 4'd1;
      CoeffAddr_o <= CoeffAddr_o + 4'd1;
    end
  end

  // Strobes are delayed to match the read/multiply pipeline of the MAC.
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      startPipe <= '0;
      validPipe <= '0;
      for (int i = 0; i < 3; i++) chanPipe[i] <= '0;
    end else begin
      startPipe   <= {startPipe[1:0], grant};
      validPipe   <= {validPipe[1:0], Busy_o && lastTap};
      chanPipe[0] <= RdChan_o;
      chanPipe[1] <= chanPipe[0];
      chanPipe[2] <= chanPipe[1];
    end
  end

  assign StartAcc_o  = startPipe[2];
  assign DataValid_o = validPipe[2];
  assign OutChan_o   = chanPipe[2];

`ifdef DECIM_SCHED_OVERRUN_EN
  logic [NumChannels-1:0] ovrSet, ovrFlag;

  always_comb begin
    ovrSet = '0;
    for (int c = 0; c < NumChannels; c++)
      ovrSet[c] = trigger[c] && pending[c] && !(grant && (winner == 2'(c)));
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) ovrFlag <= '0;
    else       ovrFlag <= (OvrClr_i ? '0 : ovrFlag) | ovrSet;
  end

  assign Overrun_o = ovrFlag;
`else
  logic unusedOvrClr;
  assign unusedOvrClr = OvrClr_i;
  assign Overrun_o    = '0;
`endif

endmodule
